// File: rtl/cdc_flag_sched.sv
// Round-robin scheduler feeding one toggle-based flag-crossing channel, spacing flags >= GAP cycles.
// Optional CDC_FLAG_SCHED_ACK_EN: adds an ack input and holds the next flag until an ack returns.
module cdc_flag_sched #(
    parameter  int N   = 4,
    parameter  int GAP = 8,
    localparam int W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
`ifdef CDC_FLAG_SCHED_ACK_EN
    input  logic         ack,
`endif
    output logic         flag,
    output logic [W-1:0] grant_id,
    output logic         busy,
    output logic [N-1:0] pending,
    output logic [N-1:0] drop
);

    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_HOLD     = 2'd2
`ifdef CDC_FLAG_SCHED_ACK_EN
        ,S_WAIT_ACK = 2'd3
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   last_q, last_d;
    logic [W-1:0]   grant_id_q, grant_id_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   drop_q, drop_d;
    logic           flag_q, flag_d;
    logic           busy_q, busy_d;
`ifdef CDC_FLAG_SCHED_ACK_EN
    logic           ack_seen_q, ack_seen_d;
`endif

    logic [W-1:0]   win;
    logic           found;
    logic [W-1:0]   idx;
    int             sum;
    logic           ack_ok;
    state_t         exit_state;
    logic           grant_now;
    logic [N-1:0]   clr;

    // Round-robin pick: first pending bit after the previous winner, wrapping modulo N.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = '0;
        sum   = 0;
        for (int k = 1; k <= N; k++) begin
            sum = (int'(last_q) + k) % N;
            idx = W'(sum);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
`ifdef CDC_FLAG_SCHED_ACK_EN
        // A same-cycle ack counts so a WAIT_ACK release costs no extra cycle.
        ack_ok = ack_seen_q | ack;
`else
        ack_ok = 1'b1;
`endif
        exit_state = (|pending_q) ? S_ISSUE : S_IDLE;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|pending_q) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cnt_d   = CW'(GAP - 1);
                state_d = S_HOLD;
            end
            S_HOLD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
`ifdef CDC_FLAG_SCHED_ACK_EN
                    state_d = ack_ok ? exit_state : S_WAIT_ACK;
`else
                    state_d = exit_state;
`endif
                end
            end
`ifdef CDC_FLAG_SCHED_ACK_EN
            S_WAIT_ACK: begin
                if (ack_ok) state_d = exit_state;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Grant bookkeeping happens on the edge entering ISSUE so every output is registered.
        grant_now  = (state_d == S_ISSUE);
        clr        = grant_now ? (N'(1) << win) : '0;
        pending_d  = (pending_q & ~clr) | req;
        drop_d     = req & pending_q & ~clr;
        grant_id_d = grant_now ? win : grant_id_q;
        last_d     = grant_now ? win : last_q;
        flag_d     = grant_now;
        busy_d     = (state_d != S_IDLE);
`ifdef CDC_FLAG_SCHED_ACK_EN
        ack_seen_d = (state_q == S_ISSUE) ? 1'b0 : (ack_seen_q | ack);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            last_q     <= W'(N - 1);
            grant_id_q <= '0;
            pending_q  <= '0;
            drop_q     <= '0;
            flag_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef CDC_FLAG_SCHED_ACK_EN
            ack_seen_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            grant_id_q <= grant_id_d;
            pending_q  <= pending_d;
            drop_q     <= drop_d;
            flag_q     <= flag_d;
            busy_q     <= busy_d;
`ifdef CDC_FLAG_SCHED_ACK_EN
            ack_seen_q <= ack_seen_d;
`endif
        end
    end

    assign flag     = flag_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;
    assign pending  = pending_q;
    assign drop     = drop_q;

endmodule

// File: tb/tb_cdc_flag_sched.sv
// Directed bench for cdc_flag_sched (N=4, GAP=8); ack scenarios build only with CDC_FLAG_SCHED_ACK_EN.
module tb_cdc_flag_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
`ifdef CDC_FLAG_SCHED_ACK_EN
    logic       ack;
`endif
    logic       flag;
    logic [1:0] grant_id;
    logic       busy;
    logic [3:0] pending;
    logic [3:0] drop;

    int n_run  = 0;
    int n_fail = 0;

    cdc_flag_sched #(.N(4), .GAP(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
`ifdef CDC_FLAG_SCHED_ACK_EN
        .ack      (ack),
`endif
        .flag     (flag),
        .grant_id (grant_id),
        .busy     (busy),
        .pending  (pending),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; "cycle c" is the interval after edge c.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic exp_flag;
        logic exp_d0;
        logic [1:0] exp_gid;

        rst = 1'b1;
        req = 4'b0000;
`ifdef CDC_FLAG_SCHED_ACK_EN
        ack = 1'b0;
`endif
        tick();

        // Reset held with all requests asserted
        req = 4'b1111;
        tick();
        tick();
        chk("rst_flag",    32'(flag),     32'd0);
        chk("rst_pending", 32'(pending),  32'd0);
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_drop",    32'(drop),     32'd0);
        chk("rst_gid",     32'(grant_id), 32'd0);
        req = 4'b0000;
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("post_rst_flag", 32'(flag),    32'd0);
            chk("post_rst_pend", 32'(pending), 32'd0);
            chk("post_rst_busy", 32'(busy),    32'd0);
        end

        // Single request on requester 2
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        chk("single_pend_c1", 32'(pending), 32'h4);
        chk("single_flag_c1", 32'(flag),    32'd0);
        chk("single_busy_c1", 32'(busy),    32'd0);
        tick();
        chk("single_flag_c2", 32'(flag),     32'd1);
        chk("single_gid_c2",  32'(grant_id), 32'd2);
        chk("single_busy_c2", 32'(busy),     32'd1);
        chk("single_pend_c2", 32'(pending),  32'd0);
        for (int c = 3; c <= 9; c++) begin
            tick();
            chk("single_busy_hold", 32'(busy), 32'd1);
            chk("single_flag_hold", 32'(flag), 32'd0);
        end
        tick();
        chk("single_busy_c10", 32'(busy),     32'd0);
        chk("single_gid_c10",  32'(grant_id), 32'd2);

        // All four requesters at once
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 35; c++) begin
            tick();
            req = 4'b0000;
            exp_flag = (c == 2) || (c == 10) || (c == 18) || (c == 26);
            chk("all_flag", 32'(flag), 32'(exp_flag));
            chk("all_drop", 32'(drop), 32'd0);
            chk("all_busy", 32'(busy), 32'((c >= 2) && (c <= 33)));
            if (exp_flag) chk("all_gid", 32'(grant_id), 32'((c - 2) / 8));
        end

        // req[0] every cycle plus a single req[3]
        do_reset();
        req = 4'b1001;
        for (int c = 1; c <= 26; c++) begin
            tick();
            req = 4'b0001;
            exp_flag = (c == 2) || (c == 10) || (c == 18) || (c == 26);
            exp_d0   = (c >= 3) && (c != 18) && (c != 26);
            exp_gid  = (c == 10) ? 2'd3 : 2'd0;
            chk("fair_flag",  32'(flag),       32'(exp_flag));
            chk("fair_drop",  32'(drop),       32'({3'b000, exp_d0}));
            chk("fair_pend0", 32'(pending[0]), 32'd1);
            chk("fair_pend3", 32'(pending[3]), 32'(c <= 9));
            if (exp_flag) chk("fair_gid", 32'(grant_id), 32'(exp_gid));
        end
        req = 4'b0000;

        // Asynchronous reset in the middle of HOLD
        do_reset();
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        chk("mid_flag_c2", 32'(flag), 32'd1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_busy",    32'(busy),     32'd0);
        chk("mid_gid",     32'(grant_id), 32'd0);
        chk("mid_pending", 32'(pending),  32'd0);
        chk("mid_flag",    32'(flag),     32'd0);
        tick();
        rst = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk("mid_after_flag", 32'(flag), 32'd0);
            chk("mid_after_busy", 32'(busy), 32'd0);
        end

`ifdef CDC_FLAG_SCHED_ACK_EN
        // Ack withheld until cycle 30
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 34; c++) begin
            tick();
            req = 4'b0000;
            ack = (c == 30);
            exp_flag = (c == 2) || (c == 31);
            chk("ack_late_flag", 32'(flag), 32'(exp_flag));
            if (c == 31) chk("ack_late_gid", 32'(grant_id), 32'd1);
        end
        ack = 1'b0;

        // Ack arrives early, GAP still governs
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            tick();
            req = 4'b0000;
            ack = (c == 5);
            exp_flag = (c == 2) || (c == 10);
            chk("ack_early_flag", 32'(flag), 32'(exp_flag));
            if (c == 10) chk("ack_early_gid", 32'(grant_id), 32'd1);
        end
        ack = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_flag_sched.md
# cdc_flag_sched

Single-clock scheduler that shares one toggle-based flag-crossing channel among N source-domain requesters. It latches single-cycle request pulses, picks one round-robin, emits a one-cycle `flag` pulse for the crossing's input, and holds a stable `grant_id` bus for the destination to sample after the flag arrives. It spaces flags at least GAP cycles apart so the destination synchronizer never merges two toggles. In the optional mode it also waits for a returned acknowledge before the next flag. It sits in the source clock domain, directly ahead of the flag-crossing synchronizer.

## Interface
- `N`, default 4: number of requesters, legal range 2–16.
- `GAP`, default 8: minimum clk cycles from one flag to the next, ≥2.
- `W`: derived as $clog2(N); not overridable.

- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester single-cycle request pulses.
- `ack`  in  1  returned acknowledge pulse; present only with CDC_FLAG_SCHED_ACK_EN.
- `flag`  out  1  one-cycle pulse, drives the crossing's input.
- `grant_id`  out  W  index of the last granted requester; changes only in the ISSUE cycle.
- `busy`  out  1  high whenever the state is not IDLE.
- `pending`  out  N  latched, not-yet-granted requests.
- `drop`  out  N  one-cycle pulse: a request arrived while already pending.

## Operation
- Reset values: `flag`=0, `grant_id`=0, `busy`=0, `pending`=0, `drop`=0.
- Reset also sets: state=IDLE, hold counter=0, round-robin pointer `last`=N-1, `ack_seen`=0.
- Pending update: `pending[i]` sets on `req[i]`.
  - It clears when granted.
  - Set and clear in the same edge: set wins, and no drop occurs.
  - `req[i]` while `pending[i]`=1 and not being cleared: `drop[i]`=1 for one cycle; pending stays 1.
- Arbitration: the winner is the first set `pending` bit scanning `last+1`, `last+2`, … modulo N.
  - `last` updates to the winner in ISSUE.
- FSM states: IDLE, ISSUE, HOLD, and WAIT_ACK (macro only).
  - IDLE: registered `pending`≠0 → ISSUE.
  - ISSUE: one cycle. `flag`=1; `grant_id`=winner; clear `pending[winner]`; clear `ack_seen`. Load the counter with GAP-1 and go to HOLD.
  - HOLD: decrement the counter each cycle. On the cycle it reaches 1, pick the next state:
    - ISSUE if `pending`≠0 (and, with the macro, `ack_seen`=1);
    - IDLE if `pending`=0 (and, with the macro, `ack_seen`=1);
    - WAIT_ACK if the macro is defined and `ack_seen`=0.
  - WAIT_ACK: stay until `ack_seen`=1, then go to ISSUE or IDLE by the same rule as HOLD.
- `ack_seen` sets on any `ack` pulse from the cycle after ISSUE onward. An `ack` during ISSUE itself is ignored.
- `grant_id` is stable from ISSUE until the next ISSUE, so the destination can sample it at any point in that interval.

## Timing
- Latency: `req[i]` high in cycle t → `pending[i]`=1 in t+1 → `flag`=1 and `grant_id`=i in t+2 (from IDLE).
- Continuous pending: flags exactly GAP cycles apart, with no IDLE cycle between them.
- `busy` runs from the ISSUE cycle through the final HOLD/WAIT_ACK cycle.
- `drop` is registered and appears one cycle after the offending `req`.
- `rst` asserted mid-operation: all outputs go to their reset values immediately (asynchronously). Any pending requests are discarded.

## Configuration
- `CDC_FLAG_SCHED_ACK_EN` defined:
  - adds the `ack` port, the WAIT_ACK state and `ack_seen`;
  - the next flag requires both GAP spacing and a received ack.
- `CDC_FLAG_SCHED_ACK_EN` undefined:
  - no `ack` port; HOLD exits on GAP alone;
  - flow is IDLE→ISSUE→HOLD→(ISSUE|IDLE).

## Test plan
All scenarios use N=4, GAP=8.
- Reset: `rst` pulse with `req`=4'b1111 → all outputs zero during and after reset; no flag until `req` is sampled post-reset.
- Single request: `req[2]` pulse at cycle 0 → `pending`=4'b0100 at cycle 1; `flag`=1 with `grant_id`=2 at cycle 2; `busy` high for cycles 2–9; IDLE at cycle 10.
- Simultaneous requests: `req`=4'b1111 at cycle 0 → flags at cycles 2, 10, 18, 26 with `grant_id` 0, 1, 2, 3; `drop` stays 0.
- Fairness and drop: `req[0]` every cycle plus a single `req[3]` at cycle 0 → `grant_id` sequence 0, 3, 0, 0…; `drop[0]` pulses on every cycle that `pending[0]` is held; set-wins on the grant edge.
- Reset mid-HOLD: `rst` at cycle 5 of the single-request scenario → `busy`=0, `grant_id`=0, `pending`=0 at once; no further flag.
- ACK mode (macro on): two requests with `ack` withheld → second flag absent after cycle 10; `ack` at cycle 30 → second flag at cycle 31.
- ACK mode, early ack: `ack` at cycle 5 → second flag at cycle 10, proving the GAP rule.
